// File: rtl/pe_pkg.sv
// Shared definitions for the priority scan encoder: FSM states, legal WIDTH range
// and a popcount helper used by the optional PE_COUNT_EN capture counter.
package pe_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } pe_state_e;

  localparam int PE_MIN_WIDTH = 2;
  localparam int PE_MAX_WIDTH = 64;

  function automatic int unsigned pe_popcount(input logic [PE_MAX_WIDTH-1:0] vec);
    int unsigned total;
    total = 0;
    for (int i = 0; i < PE_MAX_WIDTH; i++) begin
      total = total + {31'd0, vec[i]};
    end
    return total;
  endfunction

endpackage

// File: rtl/pe_find_msb.sv
// Combinational highest-set-bit search; returns 0 when the vector is empty.
module pe_find_msb #(
  parameter int WIDTH = 8,
  localparam int IDXW = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDXW-1:0]  msb
);

  // Ascending scan so the last hit, i.e. the highest set bit, wins.
  always_comb begin
    msb = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) begin
        msb = IDXW'(i);
      end
    end
  end

endmodule

// File: rtl/priority_scan_encoder.sv
// Captures a request vector and hands out its set-bit indices highest first.
// Optional feature: define PE_COUNT_EN to add the registered popcount output cnt.
module priority_scan_encoder
  import pe_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int IDXW = $clog2(WIDTH)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            pe_request,
  input  logic [WIDTH-1:0] in,
  input  logic            flush,
  input  logic            out_ready,
  output logic [IDXW-1:0] out,
  output logic            out_valid,
  output logic            pe_work,
  output logic            done,
  output logic            none
`ifdef PE_COUNT_EN
  ,
  output logic [IDXW:0]   cnt
`endif
);

  pe_state_e        state, state_next;
  logic [WIDTH-1:0] pending, pending_next;
  logic             done_next, none_next;
  logic [IDXW-1:0]  msb_idx;
  logic [WIDTH-1:0] clear_mask;

  pe_find_msb #(.WIDTH(WIDTH)) u_find_msb (
    .vec(pending),
    .msb(msb_idx)
  );

  assign clear_mask = WIDTH'(1) << msb_idx;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      pending <= '0;
      done    <= 1'b0;
      none    <= 1'b0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
      done    <= done_next;
      none    <= none_next;
    end
  end

  // Flush outranks everything; pe_request is only looked at while idle.
  always_comb begin
    state_next   = state;
    pending_next = pending;
    done_next    = 1'b0;
    none_next    = 1'b0;
    if (flush) begin
      state_next   = IDLE;
      pending_next = '0;
    end else begin
      case (state)
        IDLE: begin
          if (pe_request) begin
            if (in != '0) begin
              pending_next = in;
              state_next   = SCAN;
            end else begin
              done_next = 1'b1;
              none_next = 1'b1;
            end
          end
        end
        SCAN: begin
          if (out_ready) begin
            pending_next = pending & ~clear_mask;
            if (pending_next == '0) begin
              state_next = IDLE;
              done_next  = 1'b1;
            end
          end
        end
        default: begin
          state_next   = IDLE;
          pending_next = '0;
        end
      endcase
    end
  end

  assign out_valid = (state == SCAN);
  assign pe_work   = (state == SCAN);
  assign out       = (state == SCAN) ? msb_idx : '0;

`ifdef PE_COUNT_EN
  // Count is taken on every accepted request, including an all-zero one.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (state == IDLE && pe_request) begin
      cnt <= (IDXW+1)'(pe_popcount(PE_MAX_WIDTH'(in)));
    end
  end
`endif

endmodule

// File: doc/priority_scan_encoder.md
PRIORITY_SCAN_ENCODER -- requirements
Module: priority_scan_encoder

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the request vector width; legal values are powers of two from 2 to 64.
REQ-002 Parameter IDXW, default $clog2(WIDTH), SHALL set the index width; it SHALL be derived and never overridden.
REQ-003 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 pe_request  input  1  SHALL be the start strobe; it is sampled only in IDLE.
REQ-006 in  input  WIDTH  SHALL be the candidate vector, captured on an accepted pe_request.
REQ-007 flush  input  1  SHALL abort the current scan synchronously.
REQ-008 out_ready  input  1  SHALL be the consumer-ready signal for out.
REQ-009 out  output  IDXW  SHALL carry the index of the highest set bit still pending.
REQ-010 out_valid  output  1  SHALL mark out as valid.
REQ-011 pe_work  output  1  SHALL be high while a scan is in progress (state SCAN).
REQ-012 done  output  1  SHALL be a one-cycle pulse at the end of every completed scan.
REQ-013 none  output  1  SHALL be a one-cycle pulse, coincident with done, when the captured vector was zero.
REQ-014 cnt  output  IDXW+1  SHALL carry the popcount of the captured vector; it exists only under PE_COUNT_EN.

Function
REQ-015 The FSM SHALL have two states, IDLE and SCAN, and SHALL hold a WIDTH-bit pending register.
REQ-016 IDLE with pe_request=1 and in!=0 SHALL load pending<=in and enter SCAN on the next edge.
REQ-017 IDLE with pe_request=1 and in==0 SHALL stay in IDLE and pulse done and none on the next cycle.
REQ-018 In SCAN, out_valid SHALL be 1 and out SHALL be the highest set index of pending; latency from request to first out_valid is one cycle.
REQ-019 When out_valid and out_ready are both high, the bit pending[out] SHALL be cleared on that edge.
REQ-020 If that cleared bit was the last set bit, the FSM SHALL return to IDLE and pulse done on the next cycle.
REQ-021 While out_ready=0, out and out_valid SHALL hold stable.
REQ-022 pe_request in SCAN SHALL be ignored, with no capture and no queuing.
REQ-023 flush=1 in any state SHALL clear pending and enter IDLE on the next edge with done=0.
REQ-024 flush SHALL take priority over a simultaneous handshake or pe_request.
REQ-025 In IDLE, out SHALL be 0 and out_valid SHALL be 0.
REQ-026 The next pe_request after a scan SHALL be accepted in the same cycle that done is high.

Reset
REQ-027 While reset_n=0, the following SHALL be forced immediately (asynchronously):
- state=IDLE
- pending=0
- out=0
- out_valid=0
- pe_work=0
- done=0
- none=0
- cnt=0
REQ-028 Assertion of reset_n mid-scan SHALL discard all pending bits, with no done pulse after release.

Configuration
REQ-029 With PE_COUNT_EN defined:
- cnt SHALL be registered at capture as the popcount of in;
- cnt SHALL hold until the next capture, flush or reset.
REQ-030 Without PE_COUNT_EN, the cnt port and its logic SHALL be absent; all other behaviour SHALL be unchanged.

Structure
REQ-031 Shared package pe_pkg SHALL hold the state enum (IDLE, SCAN) and the WIDTH legality limits.
REQ-032 The highest-set-bit search SHALL live in the combinational sub-module pe_find_msb, parameterised by WIDTH.

Verification
REQ-033 WIDTH=8, in=8'b1010_0100, out_ready=1 -> out=7, 5, 2 on three consecutive cycles, then done one cycle later.
REQ-034 in=8'h00 with pe_request -> done=1 and none=1 for exactly one cycle, and out_valid never rises.
REQ-035 in=8'h81 with out_ready low for 3 cycles -> out=7 held with out_valid=1 for 4 cycles, then out=0, then done.
REQ-036 flush after first grant of 8'hF0 -> IDLE next cycle, pe_work=0, no done, and the following pe_request is accepted normally.
REQ-037 pe_request with 8'h0F during a SCAN of 8'h30 -> sequence is 5, 4 only; reset_n low mid-scan -> all outputs 0 immediately.
REQ-038 WIDTH=32, in=32'h8000_0001 -> out=31 then 0; with PE_COUNT_EN, cnt=2.
